// File: rtl/mux_3x1.sv
// Registered 3-to-1 multiplexer with one cycle of latency and an async active-low reset.
// Define MUX3X1_SEL_ERR_EN to make sel=2'b11 hold mux_out and raise sel_err; otherwise 2'b11 loads zeros.
module mux_3x1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] mux_out,
  output logic             sel_err
);

  logic [WIDTH-1:0] r_mux_out;
  logic [WIDTH-1:0] w_mux_next;

  always_comb begin
    w_mux_next = '0;
    case (sel)
      2'b00:   w_mux_next = a;
      2'b01:   w_mux_next = b;
      2'b10:   w_mux_next = c;
`ifdef MUX3X1_SEL_ERR_EN
      default: w_mux_next = r_mux_out;
`else
      default: w_mux_next = '0;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_out <= '0;
    end else begin
      r_mux_out <= w_mux_next;
    end
  end

  assign mux_out = r_mux_out;

`ifdef MUX3X1_SEL_ERR_EN
  logic w_sel_illegal;
  logic r_sel_err;

  assign w_sel_illegal = (sel == 2'b11);

  // One-cycle flag per illegal sample; clears on the next legal sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_sel_illegal;
    end
  end

  assign sel_err = r_sel_err;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_3x1.sv
// Self-checking bench for mux_3x1: a WIDTH=1 instance and a WIDTH=8 instance on a shared clock/reset.
// Expected values come from spec tables and a small reference model, queued at drive time.
module tb_mux_3x1;

`ifdef MUX3X1_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       a, b, c;
  logic [1:0] sel;
  logic       mux_out;
  logic       sel_err;
  logic [7:0] a8, b8, c8;
  logic [1:0] sel8;
  logic [7:0] mux_out8;
  logic       sel_err8;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];   // {sel_err, mux_out} for the WIDTH=1 instance
  logic [8:0] exp8_q[$];  // {sel_err, mux_out} for the WIDTH=8 instance
  logic       m_prev;     // model copy of the last expected WIDTH=1 output

  typedef struct {
    logic       a, b, c;
    logic [1:0] sel;
    logic       exp_out;
  } vec_t;

  vec_t vecs[6];

  mux_3x1 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .sel(sel),
    .mux_out(mux_out), .sel_err(sel_err)
  );

  mux_3x1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .sel(sel8),
    .mux_out(mux_out8), .sel_err(sel_err8)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model1(input logic ia, ib, ic, input logic [1:0] isel,
                                        input logic prev);
    case (isel)
      2'b00:   return {1'b0, ia};
      2'b01:   return {1'b0, ib};
      2'b10:   return {1'b0, ic};
      default: return ERR_EN ? {1'b1, prev} : 2'b00;
    endcase
  endfunction

  // Drive at negedge, queue the expectation, sample 1ns after the next rising edge.
  task automatic step1(input string name, input logic ia, ib, ic, input logic [1:0] isel,
                       input logic [1:0] exp_word);
    logic [1:0] got_exp;
    @(negedge clk);
    a = ia; b = ib; c = ic; sel = isel;
    exp_q.push_back(exp_word);
    @(posedge clk);
    #1;
    got_exp = exp_q.pop_front();
    check({name, ".out"}, mux_out, got_exp[0]);
    check({name, ".err"}, sel_err, got_exp[1]);
    m_prev = got_exp[0];
  endtask

  task automatic step8(input string name, input logic [7:0] ia, ib, ic, input logic [1:0] isel,
                       input logic [8:0] exp_word);
    logic [8:0] got_exp;
    @(negedge clk);
    a8 = ia; b8 = ib; c8 = ic; sel8 = isel;
    exp8_q.push_back(exp_word);
    @(posedge clk);
    #1;
    got_exp = exp8_q.pop_front();
    check({name, ".out8"}, mux_out8, got_exp[7:0]);
    check({name, ".err8"}, sel_err8, got_exp[8]);
  endtask

  initial begin
    logic [1:0] w;
    logic [4:0] combo;
    logic       ra, rb, rc;
    logic [1:0] rs;

    vecs[0] = '{a: 1'b1, b: 1'b0, c: 1'b0, sel: 2'b01, exp_out: 1'b0};
    vecs[1] = '{a: 1'b1, b: 1'b1, c: 1'b0, sel: 2'b10, exp_out: 1'b0};
    vecs[2] = '{a: 1'b1, b: 1'b0, c: 1'b0, sel: 2'b00, exp_out: 1'b1};
    vecs[3] = '{a: 1'b0, b: 1'b0, c: 1'b1, sel: 2'b01, exp_out: 1'b0};
    vecs[4] = '{a: 1'b1, b: 1'b0, c: 1'b0, sel: 2'b10, exp_out: 1'b0};
    vecs[5] = '{a: 1'b0, b: 1'b1, c: 1'b0, sel: 2'b00, exp_out: 1'b0};

    // Reset held with inputs that would otherwise load ones
    rst_n = 1'b0;
    a = 1'b1; b = 1'b1; c = 1'b1; sel = 2'b00;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; sel8 = 2'b00;
    m_prev = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold.out", mux_out, 1'b0);
      check("reset_hold.err", sel_err, 1'b0);
      check("reset_hold.out8", mux_out8, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Spec per-code sequence
    for (int i = 0; i < 6; i++)
      step1($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sel,
            {1'b0, vecs[i].exp_out});

    // Exhaustive 32 combinations
    for (int i = 0; i < 32; i++) begin
      combo = i[4:0];
      w = model1(combo[4], combo[3], combo[2], combo[1:0], m_prev);
      step1($sformatf("exh%0d", i), combo[4], combo[3], combo[2], combo[1:0], w);
    end

    // Random back-to-back selects
    for (int i = 0; i < 40; i++) begin
      ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1)); rs = 2'($urandom_range(0, 3));
      w = model1(ra, rb, rc, rs, m_prev);
      step1($sformatf("rnd%0d", i), ra, rb, rc, rs, w);
    end

    // Illegal select: hold (or zero) then recover on the next legal sample
    step1("ill_load", 1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    step1("ill_sel11", 1'b0, 1'b0, 1'b0, 2'b11, {ERR_EN, ERR_EN});
    step1("ill_sel11_again", 1'b0, 1'b0, 1'b0, 2'b11, {ERR_EN, ERR_EN});
    step1("ill_recover", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);

    // Async reset mid-cycle after a 1 is loaded
    step1("mid_load", 1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_reset.out", mux_out, 1'b0);
    check("mid_reset.err", sel_err, 1'b0);

    // First edge after reset release sampling sel=11
    @(negedge clk);
    a = 1'b1; b = 1'b1; c = 1'b1; sel = 2'b11;
    rst_n = 1'b1;
    exp_q.push_back({ERR_EN, 1'b0});
    @(posedge clk);
    #1;
    w = exp_q.pop_front();
    check("rel_sel11.out", mux_out, w[0]);
    check("rel_sel11.err", sel_err, w[1]);
    m_prev = w[0];
    step1("rel_legal", 1'b0, 1'b1, 1'b0, 2'b01, 2'b01);

    // WIDTH=8 stepping through codes
    step8("w8_a", 8'hA5, 8'h3C, 8'hF0, 2'b00, 9'h0A5);
    step8("w8_b", 8'hA5, 8'h3C, 8'hF0, 2'b01, 9'h03C);
    step8("w8_c", 8'hA5, 8'h3C, 8'hF0, 2'b10, 9'h0F0);
    step8("w8_sel11", 8'h11, 8'h22, 8'h33, 2'b11, ERR_EN ? 9'h1F0 : 9'h000);
    step8("w8_rec", 8'h11, 8'h22, 8'h5A, 2'b10, 9'h05A);

    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0",
               exp_q.size(), exp8_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
